// File: rtl/pico_bus_pkg.sv
// Shared constants and types for the pico_bus_router slice.
// Holds the FSM state encoding, fixed region and timer offsets, the
// default error read data and the latched request payload.
package pico_bus_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 16;

   // Router FSM states
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_RAM_WAIT  = 2'd1;
   localparam logic [1:0] ST_PERI_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP      = 2'd3;

   localparam logic [3:0] REGION_RAM    = 4'h0;
   localparam logic [3:0] REGION_TIMER  = 4'hF;
   localparam logic [3:0] TIMER_RD_OFF  = 4'h0;
   localparam logic [3:0] TIMER_CLR_OFF = 4'h4;

   localparam logic [DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

   // Request captured when an access is accepted in IDLE
   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [3:0]        wstrb;
   } bus_req_t;

endpackage

// File: rtl/pico_bus_timer.sv
// Free-running 32-bit cycle counter behind region 0xF of pico_bus_router.
// Only instantiated when PICO_BUS_TIMER_EN is defined.
// Ports: clk, resetn (async, active-low); wr = accepted write to region F;
// offset = address bits [27:0]; rdata_c = combinational read mux.
module pico_bus_timer
   import pico_bus_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              wr,
   input  logic [27:0]       offset,
   output logic [DATA_W-1:0] rdata_c
);

   logic [DATA_W-1:0] count_q;
   logic              clr_c;

   assign clr_c   = wr && (offset == 28'(TIMER_CLR_OFF));
   assign rdata_c = (offset == 28'(TIMER_RD_OFF)) ? count_q : '0;

   // Counter wraps naturally at 0xFFFF_FFFF
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    count_q <= '0;
      else if (clr_c) count_q <= '0;
      else            count_q <= count_q + 32'd1;
   end

endmodule

// File: rtl/pico_bus_router.sv
// Bus router between the picorv32 native memory interface, one RAM and
// NUM_PERI peripheral slaves, with per-access timeout, error reporting and
// a finish-address core hold. Optional macro PICO_BUS_TIMER_EN maps a
// cycle counter into region 0xF (otherwise region 0xF is an error).
// Ports: CPU side mem_*; RAM side ram_* (level strobes); peripheral side
// peri_* (one-cycle strobes, slave i in region PERI_BASE_REGION+i);
// status bus_err/err_addr, finished, cpu_resetn; host conf_sel.
module pico_bus_router
   import pico_bus_pkg::*;
#(
   parameter int unsigned NUM_PERI         = 4,
   parameter int unsigned PERI_BASE_REGION = 1,
   parameter int unsigned TIMEOUT_CYCLES   = 255,
   parameter logic [31:0] FINISH_ADDR      = 32'h2000_0000,
   parameter logic [31:0] ERR_RDATA        = DEFAULT_ERR_RDATA
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       conf_sel,
   input  logic                       mem_valid,
   input  logic [31:0]                mem_addr,
   input  logic [31:0]                mem_wdata,
   input  logic [3:0]                 mem_wstrb,
   output logic                       mem_ready,
   output logic [31:0]                mem_rdata,
   output logic                       cpu_resetn,
   output logic                       finished,
   output logic                       ram_rden,
   output logic                       ram_wren,
   output logic [31:0]                ram_addr,
   output logic [31:0]                ram_wdata,
   output logic [3:0]                 ram_wstrb,
   input  logic [31:0]                ram_rdata,
   input  logic                       ram_ready,
   output logic [NUM_PERI-1:0]        peri_rden,
   output logic [NUM_PERI-1:0]        peri_wren,
   output logic [31:0]                peri_addr,
   output logic [31:0]                peri_wdata,
   output logic [3:0]                 peri_wstrb,
   input  logic [32*NUM_PERI-1:0]     peri_rdata,
   input  logic [NUM_PERI-1:0]        peri_ready,
   output logic                       bus_err,
   output logic [31:0]                err_addr
);

   logic [1:0]          state_q, state_d;
   bus_req_t            req_q, req_d;
   logic [3:0]          sel_q, sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ram_rden_d, ram_wren_d, mem_ready_d, bus_err_d, finished_d;
   logic [NUM_PERI-1:0] peri_rden_d, peri_wren_d;
   logic [31:0]         mem_rdata_d, err_addr_d;

   logic [3:0]          region_c;
   logic                is_wr_c;
   logic [NUM_PERI-1:0] peri_hit_c;
   logic [3:0]          peri_idx_c;
   logic                sel_ready_c, wait_ready_c, timeout_c;
   logic [31:0]         sel_rdata_c, wait_rdata_c;

   assign region_c  = mem_addr[31:28];
   assign is_wr_c   = |mem_wstrb;
   assign timeout_c = (cnt_q == 16'(TIMEOUT_CYCLES));

   assign cpu_resetn = resetn & ~conf_sel & ~finished;
   assign ram_addr   = {2'b00, req_q.addr[31:2]};
   assign ram_wdata  = req_q.wdata;
   assign ram_wstrb  = req_q.wstrb;
   assign peri_addr  = req_q.addr;
   assign peri_wdata = req_q.wdata;
   assign peri_wstrb = req_q.wstrb;

`ifdef PICO_BUS_TIMER_EN
   logic        timer_wr_c;
   logic [31:0] timer_rdata_c;

   pico_bus_timer u_timer (
      .clk     (clk),
      .resetn  (resetn),
      .wr      (timer_wr_c),
      .offset  (mem_addr[27:0]),
      .rdata_c (timer_rdata_c)
   );
`endif

   // Peripheral region decode (5-bit compare avoids wrap past region 0xF)
   always_comb begin
      peri_hit_c = '0;
      peri_idx_c = '0;
      for (int unsigned i = 0; i < NUM_PERI; i++) begin
         if ({1'b0, region_c} == 5'(PERI_BASE_REGION + i)) begin
            peri_hit_c[i] = 1'b1;
            peri_idx_c    = 4'(i);
         end
      end
   end

   // Ready/rdata of the selected slave only; other slaves are ignored
   always_comb begin
      sel_ready_c = 1'b0;
      sel_rdata_c = '0;
      for (int unsigned i = 0; i < NUM_PERI; i++) begin
         if (sel_q == 4'(i)) begin
            sel_ready_c = peri_ready[i];
            sel_rdata_c = peri_rdata[32*i +: 32];
         end
      end
   end

   assign wait_ready_c = (state_q == ST_RAM_WAIT) ? ram_ready : sel_ready_c;
   assign wait_rdata_c = (state_q == ST_RAM_WAIT) ? ram_rdata : sel_rdata_c;

   // State register and all registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         req_q     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         ram_rden  <= 1'b0;
         ram_wren  <= 1'b0;
         peri_rden <= '0;
         peri_wren <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         bus_err   <= 1'b0;
         err_addr  <= '0;
         finished  <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         ram_rden  <= ram_rden_d;
         ram_wren  <= ram_wren_d;
         peri_rden <= peri_rden_d;
         peri_wren <= peri_wren_d;
         mem_ready <= mem_ready_d;
         mem_rdata <= mem_rdata_d;
         bus_err   <= bus_err_d;
         err_addr  <= err_addr_d;
         finished  <= finished_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      ram_rden_d  = ram_rden;
      ram_wren_d  = ram_wren;
      peri_rden_d = '0;
      peri_wren_d = '0;
      mem_ready_d = 1'b0;
      mem_rdata_d = '0;
      bus_err_d   = 1'b0;
      err_addr_d  = err_addr;
      finished_d  = finished & ~conf_sel;
`ifdef PICO_BUS_TIMER_EN
      timer_wr_c  = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               req_d = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
               // Finish write wins over the peripheral decode of its region
               if (is_wr_c && (mem_addr == FINISH_ADDR)) begin
                  finished_d  = ~conf_sel;
                  state_d     = ST_RESP;
                  mem_ready_d = 1'b1;
               end else if (region_c == REGION_RAM) begin
                  state_d    = ST_RAM_WAIT;
                  cnt_d      = '0;
                  ram_rden_d = ~is_wr_c;
                  ram_wren_d = is_wr_c;
               end else if (|peri_hit_c) begin
                  state_d     = ST_PERI_WAIT;
                  cnt_d       = '0;
                  sel_d       = peri_idx_c;
                  peri_rden_d = is_wr_c ? '0 : peri_hit_c;
                  peri_wren_d = is_wr_c ? peri_hit_c : '0;
               end
`ifdef PICO_BUS_TIMER_EN
               else if (region_c == REGION_TIMER) begin
                  timer_wr_c  = is_wr_c;
                  state_d     = ST_RESP;
                  mem_ready_d = 1'b1;
                  mem_rdata_d = is_wr_c ? '0 : timer_rdata_c;
               end
`endif
               else begin
                  state_d     = ST_RESP;
                  mem_ready_d = 1'b1;
                  mem_rdata_d = ERR_RDATA;
                  bus_err_d   = 1'b1;
                  err_addr_d  = mem_addr;
               end
            end
         end

         ST_RAM_WAIT, ST_PERI_WAIT: begin
            // Ready is checked first so it beats a coincident timeout
            if (wait_ready_c) begin
               state_d     = ST_RESP;
               ram_rden_d  = 1'b0;
               ram_wren_d  = 1'b0;
               mem_ready_d = 1'b1;
               mem_rdata_d = (|req_q.wstrb) ? '0 : wait_rdata_c;
            end else if (timeout_c) begin
               state_d     = ST_RESP;
               ram_rden_d  = 1'b0;
               ram_wren_d  = 1'b0;
               mem_ready_d = 1'b1;
               mem_rdata_d = ERR_RDATA;
               bus_err_d   = 1'b1;
               err_addr_d  = req_q.addr;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
